// File: rtl/iter_alu_if.sv
// Request/response bundle between the execute-stage control and the iterative ALU.
// The master issues operations and consumes results; the slave is the ALU itself.
interface iter_alu_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_ctrl;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;

   modport master (
      output in_valid, alu_ctrl, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, zero, illegal
   );

   modport slave (
      input  in_valid, alu_ctrl, src_a, src_b, out_ready,
      output in_ready, out_valid, result, zero, illegal
   );
endinterface

// File: rtl/iter_alu.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, bit-serial shifts,
// valid/ready handshakes on both sides so control can stall around long shifts.
module iter_alu #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic      clk,
   input  logic      rst,
   iter_alu_if.slave bus
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_SLL  = 4'b0010;
   localparam logic [3:0] OP_SLT  = 4'b0011;
   localparam logic [3:0] OP_SLTU = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_OR   = 4'b1000;
   localparam logic [3:0] OP_AND  = 4'b1001;
   localparam logic [3:0] OP_LUI  = 4'b1010;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SH_LEFT, SH_RIGHT, SH_ARITH} shift_kind_t;

   state_t              state_q, state_d;
   shift_kind_t         kind_q, kind_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                illegal_q, illegal_d;
   logic [SHAMT_W-1:0]  cnt_q, cnt_d;

   logic [XLEN-1:0]     op_result;
   logic                op_illegal;
   logic                op_is_shift;
   shift_kind_t         op_kind;
   logic [SHAMT_W-1:0]  shamt;
   logic [XLEN-1:0]     shifted;

   assign shamt = bus.src_b[SHAMT_W-1:0];

   always_comb begin
      op_result   = '0;
      op_illegal  = 1'b0;
      op_is_shift = 1'b0;
      op_kind     = SH_LEFT;
      case (bus.alu_ctrl)
         OP_ADD:  op_result = bus.src_a + bus.src_b;
         OP_SUB:  op_result = bus.src_a - bus.src_b;
         OP_SLT:  op_result = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
         OP_SLTU: op_result = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
         OP_XOR:  op_result = bus.src_a ^ bus.src_b;
         OP_OR:   op_result = bus.src_a | bus.src_b;
         OP_AND:  op_result = bus.src_a & bus.src_b;
         OP_LUI:  op_result = bus.src_b;
         OP_SLL: begin
            op_is_shift = 1'b1;
            op_kind     = SH_LEFT;
         end
         OP_SRL: begin
            op_is_shift = 1'b1;
            op_kind     = SH_RIGHT;
         end
         OP_SRA: begin
            op_is_shift = 1'b1;
            op_kind     = SH_ARITH;
         end
         default: op_illegal = 1'b1;
      endcase
   end

   // The result register doubles as the shift register, so no separate datapath is needed.
   always_comb begin
      shifted = result_q;
      case (kind_q)
         SH_LEFT:  shifted = {result_q[XLEN-2:0], 1'b0};
         SH_RIGHT: shifted = {1'b0, result_q[XLEN-1:1]};
         SH_ARITH: shifted = {result_q[XLEN-1], result_q[XLEN-1:1]};
         default:  shifted = result_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      result_d  = result_q;
      illegal_d = illegal_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               illegal_d = op_illegal;
               if (op_is_shift) begin
                  result_d = bus.src_a;
                  cnt_d    = shamt;
                  kind_d   = op_kind;
                  state_d  = (shamt == '0) ? DONE : SHIFT;
               end else begin
                  result_d = op_result;
                  state_d  = DONE;
               end
            end
         end
         SHIFT: begin
            result_d = shifted;
            cnt_d    = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         kind_q    <= SH_LEFT;
         result_q  <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.zero      = (result_q == '0);
   assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: directed ops push expected responses at acceptance,
// an independent monitor pops and compares them at each output handoff.
module tb_iter_alu;

   localparam int XLEN = 32;

   typedef struct {
      string           name;
      logic [3:0]      ctrl;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] exp_result;
      logic            exp_zero;
      logic            exp_illegal;
      int              exp_lat;
   } vec_t;

   typedef struct {
      string           name;
      logic [XLEN-1:0] exp_result;
      logic            exp_zero;
      logic            exp_illegal;
      int              exp_lat;
      int              accept_cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   total_checks;
   int   passed_checks;
   int   first_valid_cyc;
   bit   seen_valid;
   exp_t sb[$];

   iter_alu_if #(.XLEN(XLEN)) bus ();

   iter_alu #(.XLEN(XLEN), .SHAMT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                              input logic [XLEN-1:0] expected);
      total_checks = total_checks + 1;
      if (actual === expected) begin
         passed_checks = passed_checks + 1;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Drives one request, holds it until accepted, and records the expected response.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      bit   accepted;
      accepted = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.alu_ctrl = v.ctrl;
      bus.src_a    = v.a;
      bus.src_b    = v.b;
      for (int i = 0; i < 100 && !accepted; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            e.name        = v.name;
            e.exp_result  = v.exp_result;
            e.exp_zero    = v.exp_zero;
            e.exp_illegal = v.exp_illegal;
            e.exp_lat     = v.exp_lat;
            e.accept_cyc  = cyc + 1;
            sb.push_back(e);
            accepted = 1'b1;
            @(posedge clk);
            #1;
         end
      end
      bus.in_valid = 1'b0;
      bus.alu_ctrl = 4'hx;
      bus.src_a    = 'x;
      bus.src_b    = 'x;
      if (!accepted) begin
         total_checks = total_checks + 1;
         $display("[TB] FAIL %s accept: in_ready never rose within 100 cycles", v.name);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total_checks = total_checks + 1;
         $display("[TB] FAIL drain: %0d responses still pending after 200 cycles", sb.size());
      end
   endtask

   // Monitor: latches when out_valid rises and checks each handoff against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (bus.out_valid && !seen_valid) begin
         seen_valid      = 1'b1;
         first_valid_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready && !rst) begin
         if (sb.size() == 0) begin
            total_checks = total_checks + 1;
            $display("[TB] FAIL unexpected_out_valid: got result 0x%08h, expected no response",
                     bus.result);
         end else begin
            e = sb.pop_front();
            checkOutput({e.name, ".result"}, bus.result, e.exp_result);
            checkOutput({e.name, ".zero"}, XLEN'(bus.zero), XLEN'(e.exp_zero));
            checkOutput({e.name, ".illegal"}, XLEN'(bus.illegal), XLEN'(e.exp_illegal));
            checkOutput({e.name, ".latency"}, XLEN'(first_valid_cyc - e.accept_cyc + 1),
                        XLEN'(e.exp_lat));
         end
      end
      if (!bus.out_valid) seen_valid = 1'b0;
   end

   vec_t vecs[$];

   initial begin
      vec_t v;
      int   n;
      cyc           = 0;
      total_checks  = 0;
      passed_checks = 0;
      seen_valid    = 1'b0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.alu_ctrl  = 4'h0;
      bus.src_a     = '0;
      bus.src_b     = '0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset.in_ready", XLEN'(bus.in_ready), 1);
      checkOutput("reset.out_valid", XLEN'(bus.out_valid), 0);
      checkOutput("reset.result", bus.result, 0);
      checkOutput("reset.zero", XLEN'(bus.zero), 1);
      checkOutput("reset.illegal", XLEN'(bus.illegal), 0);

      vecs = '{
         '{"add_5_7",    4'b0000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1},
         '{"sub_eq",     4'b0001, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b0, 1},
         '{"add_wrap",   4'b0000, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 1'b0, 1},
         '{"sub_wrap",   4'b0001, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1},
         '{"slt_neg",    4'b0011, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1},
         '{"sltu_big",   4'b0100, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1},
         '{"lui",        4'b1010, 32'h0,        32'hABCDE000, 32'hABCDE000, 1'b0, 1'b0, 1},
         '{"or",         4'b1000, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, 1},
         '{"sra_4",      4'b0111, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 5},
         '{"srl_4",      4'b0110, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 5},
         '{"sll_hi_b",   4'b0010, 32'd1,        32'h25,       32'h00000020, 1'b0, 1'b0, 6},
         '{"sll_0",      4'b0010, 32'h12345678, 32'd0,        32'h12345678, 1'b0, 1'b0, 1},
         '{"sra_0_hi_b", 4'b0111, 32'h87654321, 32'h40,       32'h87654321, 1'b0, 1'b0, 1},
         '{"srl_31",     4'b0110, 32'hFFFFFFFF, 32'd31,       32'h00000001, 1'b0, 1'b0, 32},
         '{"sll_31",     4'b0010, 32'hFFFFFFFF, 32'd31,       32'h80000000, 1'b0, 1'b0, 32},
         '{"sra_31_pos", 4'b0111, 32'h7FFFFFFF, 32'd31,       32'h00000000, 1'b1, 1'b0, 32},
         '{"illegal_c",  4'b1100, 32'h5,        32'h7,        32'h0,        1'b1, 1'b1, 1},
         '{"and_after",  4'b1001, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0, 1},
         '{"illegal_f",  4'b1111, 32'h1,        32'h1,        32'h0,        1'b1, 1'b1, 1}
      };
      foreach (vecs[i]) applyStimulus(vecs[i]);
      drain();

      // Backpressure: result must sit still while the consumer stalls.
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      v = '{"xor_bp", 4'b0101, 32'hF0F0, 32'h0FF0, 32'hFF00, 1'b0, 1'b0, 1};
      applyStimulus(v);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 4; i++) begin
         checkOutput("bp.out_valid", XLEN'(bus.out_valid), 1);
         checkOutput("bp.result", bus.result, 32'hFF00);
         checkOutput("bp.in_ready", XLEN'(bus.in_ready), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_release.in_ready", XLEN'(bus.in_ready), 1);
      checkOutput("bp_release.out_valid", XLEN'(bus.out_valid), 0);
      checkOutput("bp_release.sb_empty", XLEN'(sb.size()), 0);

      // Reset in the fifth SHIFT cycle of a long shift: op is discarded, nothing pushed.
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.alu_ctrl = 4'b0010;
      bus.src_a    = 32'd3;
      bus.src_b    = 32'd20;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid.out_valid", XLEN'(bus.out_valid), 0);
      checkOutput("rst_mid.in_ready", XLEN'(bus.in_ready), 1);
      checkOutput("rst_mid.result", bus.result, 0);
      checkOutput("rst_mid.zero", XLEN'(bus.zero), 1);
      v = '{"add_after_rst", 4'b0000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1};
      applyStimulus(v);
      drain();
      repeat (25) @(negedge clk);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
